// File: rtl/simon_dec.sv
// simon_dec -- Simon 32/64 block-decryption engine.
//
// Takes a 32-bit ciphertext over a valid/ready handshake and applies the
// inverse Simon round iteratively. Round keys are consumed in descending
// order, from key[ROUNDS-1] down to key[0]. The plaintext is returned over
// a second valid/ready handshake. Only one block is in flight at a time.
//
// Build option: define SIMON_DEC_ROUND2_EN to evaluate two inverse rounds
// per RUN cycle. This halves the latency, and the results are bit-identical.
//
// Parameters:
//   ROUNDS     number of decryption rounds (even, 2..32)
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   key        [31:0][15:0] round-key array; must be stable while key_valid is high
//   key_valid  key array usable (gates acceptance only)
//   ct         ciphertext {x, y}
//   ct_valid   ciphertext offered
//   ct_ready   block idle and able to accept
//   pt         plaintext {x, y}, held until the next result
//   pt_valid   plaintext available
//   pt_ready   downstream accepts the plaintext
module simon_dec #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0][15:0] key,
  input  logic             key_valid,
  input  logic [31:0]      ct,
  input  logic             ct_valid,
  output logic             ct_ready,
  output logic [31:0]      pt,
  output logic             pt_valid,
  input  logic             pt_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [4:0] LP_RND_FIRST = 5'(ROUNDS - 1);
`ifdef SIMON_DEC_ROUND2_EN
  localparam logic [4:0] LP_RND_STEP  = 5'd2;
`else
  localparam logic [4:0] LP_RND_STEP  = 5'd1;
`endif

  state_t      r_state;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [4:0]  r_rnd;
  logic [31:0] r_pt;
  logic        r_pt_valid;

  logic [15:0] w_x1;
  logic [15:0] w_y1;
  logic [15:0] w_xn;
  logic [15:0] w_yn;
  logic        w_last;

  // f(v) = (rotl1(v) & rotl8(v)) ^ rotl2(v)
  function automatic logic [15:0] f_simon(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  always_comb begin
    w_x1 = r_y;
    w_y1 = r_x ^ f_simon(r_y) ^ key[r_rnd];
`ifdef SIMON_DEC_ROUND2_EN
    // Second round chained on the first. Because rnd starts odd and steps
    // by 2, the pair ending at key[0] is the one entered with rnd == 1.
    w_xn   = w_y1;
    w_yn   = w_x1 ^ f_simon(w_y1) ^ key[r_rnd - 5'd1];
    w_last = (r_rnd == 5'd1);
`else
    w_xn   = w_x1;
    w_yn   = w_y1;
    w_last = (r_rnd == 5'd0);
`endif
  end

  assign ct_ready = (r_state == S_IDLE) && key_valid && rst;
  assign pt       = r_pt;
  assign pt_valid = r_pt_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_rnd      <= '0;
      r_pt       <= '0;
      r_pt_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ct_valid && ct_ready) begin
            r_x     <= ct[31:16];
            r_y     <= ct[15:0];
            r_rnd   <= LP_RND_FIRST;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_x <= w_xn;
          r_y <= w_yn;
          if (w_last) begin
            r_pt       <= {w_xn, w_yn};
            r_pt_valid <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_rnd <= r_rnd - LP_RND_STEP;
          end
        end
        S_DONE: begin
          if (pt_ready) begin
            r_pt_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_pt_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_dec.sv
// Self-checking bench for simon_dec. Expected plaintexts are produced by a
// software Simon 32/64 model (key schedule plus forward encryption). Random
// plaintexts are encrypted in the model, and the DUT must decrypt them back.
module tb_simon_dec;

`ifdef SIMON_DEC_ROUND2_EN
  localparam int LAT32 = 16;
  localparam int LAT8  = 4;
`else
  localparam int LAT32 = 32;
  localparam int LAT8  = 8;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0][15:0] key;
  logic             key_valid;
  logic [31:0]      ct;
  logic             ct_valid;
  logic             ct_ready;
  logic [31:0]      pt;
  logic             pt_valid;
  logic             pt_ready;

  logic [31:0]      ct8;
  logic             ct_valid8;
  logic             ct_ready8;
  logic [31:0]      pt8;
  logic             pt_valid8;
  logic             pt_ready8;

  always #5 clk = ~clk;

  simon_dec #(.ROUNDS(32)) dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
    .ct(ct), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .pt(pt), .pt_valid(pt_valid), .pt_ready(pt_ready)
  );

  simon_dec #(.ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
    .ct(ct8), .ct_valid(ct_valid8), .ct_ready(ct_ready8),
    .pt(pt8), .pt_valid(pt_valid8), .pt_ready(pt_ready8)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int npush = 0;
  int npop  = 0;
  int bp_hold = 0;
  bit rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] v;
    int          acc;
  } exp_t;
  exp_t q[$];

  // ---------------- reference model ----------------
  logic [15:0] rk[32];

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] fm(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] p, input int nr);
    logic [15:0] x, y, t;
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < nr; i++) begin
      t = x;
      x = y ^ fm(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic build_keys();
    logic [61:0] z;
    logic [15:0] tmp;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    rk[0] = 16'h0100;
    rk[1] = 16'h0908;
    rk[2] = 16'h1110;
    rk[3] = 16'h1918;
    for (int i = 0; i < 28; i++) begin
      tmp = ror(rk[i+3], 3) ^ rk[i+1];
      tmp = tmp ^ ror(tmp, 1);
      rk[i+4] = ~rk[i] ^ tmp ^ {15'd0, z[61-i]} ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) key[i] = rk[i];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit prev_v;
    bit chk_idle;
    prev_v   = 1'b0;
    chk_idle = 1'b0;
    pt_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (pt_valid) begin
        if (q.size() == 0) begin
          check("unexpected_pt_valid", 32'(pt_valid), 32'd0);
          pt_ready = 1'b1;
        end else begin
          if (!prev_v) check("latency", 32'(cyc - q[0].acc), 32'(LAT32));
          check("pt_value", pt, q[0].v);
          check("ct_ready_busy", 32'(ct_ready), 32'd0);
          if (bp_hold > 0) begin
            pt_ready = 1'b0;
            bp_hold--;
          end else if (rdy_rand) begin
            pt_ready = 1'($urandom_range(0, 1));
          end else begin
            pt_ready = 1'b1;
          end
          if (pt_ready) begin
            void'(q.pop_front());
            npop++;
            chk_idle = 1'b1;
          end
        end
      end else begin
        if (chk_idle) check("idle_after_hs", 32'(ct_ready), 32'(key_valid));
        chk_idle = 1'b0;
        pt_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_v = pt_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] c, input logic [31:0] e, output int acc);
    ct       = c;
    ct_valid = 1'b1;
    acc      = -1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (ct_ready) begin
        acc = cyc + 1;
        q.push_back('{v: e, acc: acc});
        npush++;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    ct_valid = 1'b0;
    if (acc < 0) fail_now("send_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc;
    logic [31:0] p;
    rst       = 1'b0;
    key_valid = 1'b0;
    ct        = '0;
    ct_valid  = 1'b0;
    ct8       = '0;
    ct_valid8 = 1'b0;
    pt_ready8 = 1'b1;
    build_keys();
    check("model_vector", enc(32'h65656877, 32), 32'hc69be9bb);

    repeat (3) @(negedge clk);
    #1;
    check("rst_pt", pt, 32'd0);
    check("rst_pt_valid", 32'(pt_valid), 32'd0);
    check("rst_ct_ready", 32'(ct_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Acceptance is gated by key_valid.
    ct       = 32'hc69be9bb;
    ct_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("gate_ct_ready", 32'(ct_ready), 32'd0);
      @(negedge clk);
    end
    key_valid = 1'b1;
    #1;
    check("gate_raise", 32'(ct_ready), 32'd1);
    send(32'hc69be9bb, 32'h65656877, acc);
    drain();

    // Backpressure: result must hold for 10 cycles of pt_ready low.
    bp_hold = 10;
    send(32'hc69be9bb, 32'h65656877, acc);
    drain();

    // Reset during round 15 discards the block.
    send(32'hc69be9bb, 32'h65656877, acc);
    for (int i = 0; i < 100 && cyc < acc + 15; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    q.delete();
    npush--;
    check("midrst_pt", pt, 32'd0);
    check("midrst_pt_valid", 32'(pt_valid), 32'd0);
    check("midrst_ct_ready", 32'(ct_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      check("midrst_no_output", 32'(pt_valid), 32'd0);
      @(negedge clk);
    end
    send(32'hc69be9bb, 32'h65656877, acc);
    drain();

    // Random back-to-back traffic with gaps on both handshakes.
    rdy_rand = 1'b1;
    for (int i = 0; i < 50; i++) begin
      p = $urandom;
      send(enc(p, 32), p, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    rdy_rand = 1'b0;
    check("block_count", 32'(npop), 32'(npush));

    // ROUNDS = 8 instance
    ct8       = enc(32'h65656877, 8);
    ct_valid8 = 1'b1;
    #1;
    check("r8_ct_ready", 32'(ct_ready8), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    ct_valid8 = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        #1;
        if (pt_valid8) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) fail_now("r8_timeout");
      else begin
        check("r8_latency", 32'(cyc - acc), 32'(LAT8));
        check("r8_pt", pt8, 32'h65656877);
      end
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
